// File: rtl/jk_pkg.sv
// Shared definitions for the JK excitation driver.
//   jk_state_t : controller states (IDLE, DRIVE, CHECK)
//   jk_pair_t  : 2-bit excitation pair, packed as {J, K}
//   jk_excite  : per-bit excitation that moves a JK flip-flop from S to T
package jk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_CHECK = 2'd2
  } jk_state_t;

  // Encoded as {J, K}. TOGGLE exists only to name the pair; it is never issued.
  typedef enum logic [1:0] {
    EXC_HOLD   = 2'b00,
    EXC_RESET  = 2'b01,
    EXC_SET    = 2'b10,
    EXC_TOGGLE = 2'b11
  } jk_pair_t;

  // Equal S/T always holds (00), never toggles, so J&K can never both be 1.
  function automatic jk_pair_t jk_excite(input logic s, input logic t);
    jk_pair_t p;
    case ({s, t})
      2'b01:   p = EXC_SET;
      2'b10:   p = EXC_RESET;
      default: p = EXC_HOLD;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/jk_tgt_fifo.sv
// Target-word FIFO feeding the JK excitation controller.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset (empties the FIFO)
//   push, push_data : write request and word; ignored while full
//   pop             : read request; ignored while empty
//   head            : word at the read pointer (valid when !empty)
//   empty, full     : occupancy flags from registered pointers
// DEPTH must be a power of two and at least 2.
module jk_tgt_fifo
  import jk_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  // Storage and pointer update; a word written this edge is readable next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= {(AW + 1){1'b0}};
      rd_ptr <= {(AW + 1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= {WIDTH{1'b0}};
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/jk_excitation_driver.sv
// Converts a stream of requested JK-bank states into J/K excitation commands.
// Each word is issued for one DRIVE cycle, then verified against the bank
// feedback in a CHECK cycle.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   tgt_valid/tgt_data  : offered target word
//   tgt_ready           : FIFO not full
//   j_out, k_out        : registered excitation, non-zero only in DRIVE
//   jk_strobe           : high for the single DRIVE cycle of each word
//   q_fb                : feedback from the driven JK bank
//   busy                : controller active or words still buffered
//   mismatch            : sticky feedback error flag
//   xfer_cnt            : completed words, modulo 2^16
module jk_excitation_driver
  import jk_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tgt_valid,
  input  logic [WIDTH-1:0] tgt_data,
  output logic             tgt_ready,
  output logic [WIDTH-1:0] j_out,
  output logic [WIDTH-1:0] k_out,
  output logic             jk_strobe,
  input  logic [WIDTH-1:0] q_fb,
  output logic             busy,
  output logic             mismatch,
  output logic [15:0]      xfer_cnt
);

  jk_state_t        state;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] shadow;
  logic [15:0]      cnt;
  logic             fifo_empty;
  logic             fifo_full;
  logic [WIDTH-1:0] fifo_head;
  logic             start_word;
  logic [WIDTH-1:0] j_next;
  logic [WIDTH-1:0] k_next;
  jk_pair_t         pair;

  jk_tgt_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (tgt_valid && tgt_ready),
    .push_data (tgt_data),
    .pop       (start_word),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign tgt_ready = !fifo_full;
  assign busy      = (state != ST_IDLE) || !fifo_empty;
  assign xfer_cnt  = cnt;

  // A new word is taken from IDLE or straight out of CHECK, giving 2 cycles per word.
  always_comb begin
    start_word = 1'b0;
    case (state)
      ST_IDLE:  start_word = !fifo_empty;
      ST_CHECK: start_word = !fifo_empty;
      default:  start_word = 1'b0;
    endcase
  end

  // Excitation for the FIFO head; shadow already holds the bank state when a word starts.
  always_comb begin
    j_next = {WIDTH{1'b0}};
    k_next = {WIDTH{1'b0}};
    pair   = EXC_HOLD;
    for (int i = 0; i < WIDTH; i++) begin
      pair                 = jk_excite(shadow[i], fifo_head[i]);
      {j_next[i], k_next[i]} = pair;
    end
  end

  // Controller: outputs are registered so the command lines up with the DRIVE state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      target    <= {WIDTH{1'b0}};
      shadow    <= {WIDTH{1'b0}};
      j_out     <= {WIDTH{1'b0}};
      k_out     <= {WIDTH{1'b0}};
      jk_strobe <= 1'b0;
      mismatch  <= 1'b0;
      cnt       <= 16'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_word) begin
            state     <= ST_DRIVE;
            target    <= fifo_head;
            j_out     <= j_next;
            k_out     <= k_next;
            jk_strobe <= 1'b1;
          end else begin
            j_out     <= {WIDTH{1'b0}};
            k_out     <= {WIDTH{1'b0}};
            jk_strobe <= 1'b0;
          end
        end
        ST_DRIVE: begin
          state     <= ST_CHECK;
          shadow    <= target;
          j_out     <= {WIDTH{1'b0}};
          k_out     <= {WIDTH{1'b0}};
          jk_strobe <= 1'b0;
        end
        ST_CHECK: begin
          if (q_fb != shadow) begin
            mismatch <= 1'b1;
          end
          cnt <= cnt + 16'd1;
          if (start_word) begin
            state     <= ST_DRIVE;
            target    <= fifo_head;
            j_out     <= j_next;
            k_out     <= k_next;
            jk_strobe <= 1'b1;
          end else begin
            state     <= ST_IDLE;
            j_out     <= {WIDTH{1'b0}};
            k_out     <= {WIDTH{1'b0}};
            jk_strobe <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          j_out     <= {WIDTH{1'b0}};
          k_out     <= {WIDTH{1'b0}};
          jk_strobe <= 1'b0;
        end
      endcase
    end
  end

endmodule
